// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared display codes, op codes and sequencer state type
package calc_pkg;

  localparam logic [1:0] ESTATE_A   = 2'b00;
  localparam logic [1:0] ESTATE_B   = 2'b01;
  localparam logic [1:0] ESTATE_RES = 2'b10;
  localparam logic [1:0] ESTATE_OFF = 2'b11;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_CALC,
    ST_SHOW,
    ST_BLANK
  } calc_state_t;

  // CALC shares the operand-B display code so the user keeps seeing B while the ALU works
  function automatic logic [1:0] estate_of(input calc_state_t s);
    case (s)
      ST_ENTER_A:        return ESTATE_A;
      ST_ENTER_B,
      ST_CALC:           return ESTATE_B;
      ST_SHOW:           return ESTATE_RES;
      default:           return ESTATE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - rising-edge detector for a debounced button level
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn;
  end

  assign pulse = btn & ~btn_q;

endmodule

// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - calculator sequencer: operand entry, ALU handshake, result display, idle blanking
module calc_seq #(
  parameter int WIDTH        = 8,
  parameter int CALC_TIMEOUT = 16,
  parameter int IDLE_CYCLES  = 1_500_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       op_sel,
  input  logic             btn_enter,
  input  logic             btn_clear,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  input  logic             alu_done,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [1:0]       estate,
  output logic [WIDTH-1:0] mem1,
  output logic [WIDTH-1:0] mem2,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  import calc_pkg::*;

  localparam int CW = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT) : 1;
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CW-1:0] CALC_LAST = CW'(CALC_TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

  logic enter_e, clear_e, any_e;
  calc_state_t state_q, state_d, saved_q, saved_d;
  logic [CW-1:0] calc_cnt, calc_d;
  logic [IW-1:0] idle_cnt, idle_d;
  logic idle_hit, calc_expired, counting;

  logic [WIDTH-1:0] mem1_d, mem2_d, result_d;
  logic             err_d, alu_start_d;
  logic [1:0]       alu_op_d;

  btn_edge u_enter_edge (.clk(clk), .rst(rst), .btn(btn_enter), .pulse(enter_e));
  btn_edge u_clear_edge (.clk(clk), .rst(rst), .btn(btn_clear), .pulse(clear_e));

  assign any_e        = enter_e | clear_e;
  assign idle_hit     = (idle_cnt == IDLE_LAST);
  assign calc_expired = (calc_cnt == CALC_LAST);
  assign counting     = (state_q == ST_ENTER_A) || (state_q == ST_ENTER_B) || (state_q == ST_SHOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ENTER_A;
      saved_q   <= ST_ENTER_A;
      calc_cnt  <= '0;
      idle_cnt  <= '0;
      estate    <= ESTATE_A;
      mem1      <= '0;
      mem2      <= '0;
      result    <= '0;
      err       <= 1'b0;
      alu_op    <= 2'd0;
      alu_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      calc_cnt  <= calc_d;
      idle_cnt  <= idle_d;
      estate    <= estate_of(state_d);
      mem1      <= mem1_d;
      mem2      <= mem2_d;
      result    <= result_d;
      err       <= err_d;
      alu_op    <= alu_op_d;
      alu_start <= alu_start_d;
    end
  end

  // Clear always outranks enter; in BLANK any press only wakes the display
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    calc_d  = '0;
    unique case (state_q)
      ST_ENTER_A: begin
        if (clear_e)       state_d = ST_ENTER_A;
        else if (enter_e)  state_d = ST_ENTER_B;
        else if (idle_hit) begin state_d = ST_BLANK; saved_d = state_q; end
      end
      ST_ENTER_B: begin
        if (clear_e)       state_d = ST_ENTER_A;
        else if (enter_e)  state_d = ST_CALC;
        else if (idle_hit) begin state_d = ST_BLANK; saved_d = state_q; end
      end
      ST_CALC: begin
        if (clear_e)           state_d = ST_ENTER_A;
        else if (alu_done)     state_d = ST_SHOW;
        else if (calc_expired) state_d = ST_SHOW;
        else                   calc_d  = calc_cnt + 1'b1;
      end
      ST_SHOW: begin
        if (any_e)         state_d = ST_ENTER_A;
        else if (idle_hit) begin state_d = ST_BLANK; saved_d = state_q; end
      end
      ST_BLANK: begin
        if (any_e) state_d = saved_q;
      end
      default: state_d = ST_ENTER_A;
    endcase
    idle_d = (any_e || (state_d != state_q) || !counting) ? '0 : idle_cnt + 1'b1;
  end

  always_comb begin
    mem1_d      = mem1;
    mem2_d      = mem2;
    result_d    = result;
    err_d       = err;
    alu_op_d    = alu_op;
    alu_start_d = 1'b0;
    unique case (state_q)
      ST_ENTER_A: begin
        mem1_d = sw;
        if (clear_e) begin mem2_d = '0; result_d = '0; err_d = 1'b0; end
      end
      ST_ENTER_B: begin
        mem2_d = sw;
        if (clear_e) begin
          mem2_d = '0; result_d = '0; err_d = 1'b0;
        end else if (enter_e) begin
          alu_op_d    = op_sel;
          alu_start_d = 1'b1;
        end
      end
      ST_CALC: begin
        if (clear_e) begin
          mem2_d = '0; result_d = '0; err_d = 1'b0;
        end else if (alu_done) begin
          result_d = alu_result; err_d = alu_err;
        end else if (calc_expired) begin
          result_d = '1; err_d = 1'b1;
        end
      end
      ST_SHOW: begin
        if (any_e) begin mem2_d = '0; result_d = '0; err_d = 1'b0; end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_seq.sv
// tb/tb_calc_seq.sv - self-checking bench for calc_seq with an arithmetic ALU reference
module tb_calc_seq;
  import calc_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic [1:0]   op_sel;
  logic         btn_enter, btn_clear;
  logic [W-1:0] alu_result;
  logic         alu_err, alu_done;
  logic         alu_start;
  logic [1:0]   alu_op, estate;
  logic [W-1:0] mem1, mem2, result;
  logic         err;

  logic [1:0]   exp_estate, exp_op;
  logic [W-1:0] exp_mem1, exp_mem2, exp_result;
  logic         exp_err, exp_start;

  int total = 0;
  int bad   = 0;

  calc_seq #(.WIDTH(W), .CALC_TIMEOUT(4), .IDLE_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .sw(sw), .op_sel(op_sel),
    .btn_enter(btn_enter), .btn_clear(btn_clear),
    .alu_result(alu_result), .alu_err(alu_err), .alu_done(alu_done),
    .alu_start(alu_start), .alu_op(alu_op), .estate(estate),
    .mem1(mem1), .mem2(mem2), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":estate"},    32'(estate),    32'(exp_estate));
    chk({tag, ":mem1"},      32'(mem1),      32'(exp_mem1));
    chk({tag, ":mem2"},      32'(mem2),      32'(exp_mem2));
    chk({tag, ":result"},    32'(result),    32'(exp_result));
    chk({tag, ":err"},       32'(err),       32'(exp_err));
    chk({tag, ":alu_op"},    32'(alu_op),    32'(exp_op));
    chk({tag, ":alu_start"}, 32'(alu_start), 32'(exp_start));
  endtask

  // {error, value} the ALU would return: carry for add, borrow for sub
  function automatic logic [W:0] alu_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {(a < b), W'(a - b)};
      OP_AND:  return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  task automatic to_calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    tick();
    sw = a; btn_enter = 1'b1; tick(); btn_enter = 1'b0;
    exp_mem1 = a; exp_estate = ESTATE_B;
    check_outputs("enter_a");
    sw = b; op_sel = op; tick();
    exp_mem2 = b;
    check_outputs("enter_b");
    btn_enter = 1'b1; tick(); btn_enter = 1'b0;
    exp_start = 1'b1; exp_op = op;
    check_outputs("start");
    exp_start = 1'b0;
  endtask

  task automatic to_show(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op, input int delay);
    logic [W:0] r;
    to_calc(a, b, op);
    sw = W'($urandom);
    repeat (delay) begin tick(); check_outputs("calc_wait"); end
    r = alu_ref(op, a, b);
    alu_done = 1'b1; alu_result = r[W-1:0]; alu_err = r[W];
    tick();
    alu_done = 1'b0; alu_err = 1'b0; alu_result = W'($urandom);
    exp_result = r[W-1:0]; exp_err = r[W]; exp_estate = ESTATE_RES;
    check_outputs("show");
  endtask

  task automatic back_to_a(input bit use_clear);
    if (use_clear) btn_clear = 1'b1; else btn_enter = 1'b1;
    tick();
    btn_clear = 1'b0; btn_enter = 1'b0;
    exp_mem2 = '0; exp_result = '0; exp_err = 1'b0; exp_estate = ESTATE_A;
    check_outputs("back_to_a");
  endtask

  initial begin
    rst = 1'b1; sw = '0; op_sel = 2'd0; btn_enter = 1'b0; btn_clear = 1'b0;
    alu_result = '0; alu_err = 1'b0; alu_done = 1'b0;
    exp_estate = ESTATE_A; exp_op = 2'd0; exp_mem1 = '0; exp_mem2 = '0;
    exp_result = '0; exp_err = 1'b0; exp_start = 1'b0;
    tick(); tick();
    check_outputs("reset");
    rst = 1'b0;

    // normal flow, done two cycles after start
    to_show(8'h12, 8'h34, OP_ADD, 2);
    chk("normal_result", 32'(result), 32'h46);
    back_to_a(1'b0);

    // timeout after exactly four CALC cycles
    to_calc(8'hA5, 8'h0F, OP_SUB);
    for (int i = 1; i < 4; i++) begin tick(); check_outputs("to_wait"); end
    tick();
    exp_result = 8'hFF; exp_err = 1'b1; exp_estate = ESTATE_RES;
    check_outputs("timeout");
    back_to_a(1'b1);

    // done in the last CALC cycle beats the timeout
    to_show(8'h9C, 8'h9C, OP_ADD, 3);
    back_to_a(1'b0);

    // enter and clear together in ENTER_B: clear wins, late done ignored
    tick();
    sw = 8'h21; btn_enter = 1'b1; tick(); btn_enter = 1'b0;
    exp_mem1 = 8'h21; exp_estate = ESTATE_B;
    check_outputs("cw_b");
    sw = 8'h43; btn_enter = 1'b1; btn_clear = 1'b1; tick();
    btn_enter = 1'b0; btn_clear = 1'b0;
    exp_estate = ESTATE_A; exp_mem2 = '0;
    check_outputs("clear_wins");
    alu_done = 1'b1; alu_result = 8'h99; alu_err = 1'b1; tick();
    alu_done = 1'b0; alu_err = 1'b0;
    exp_mem1 = sw;
    check_outputs("late_done");

    // clear during CALC, then a stale completion
    to_calc(8'h05, 8'h06, OP_OR);
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
    exp_estate = ESTATE_A; exp_mem2 = '0;
    check_outputs("clear_calc");
    alu_done = 1'b1; alu_result = 8'h77; tick(); alu_done = 1'b0;
    exp_mem1 = sw;
    check_outputs("stale_done");

    // idle blanking in SHOW, clear press only wakes it
    to_show(8'h0C, 8'h0A, OP_AND, 1);
    repeat (19) tick();
    check_outputs("show_last");
    tick();
    exp_estate = ESTATE_OFF;
    check_outputs("blank_show");
    sw = 8'h5A; repeat (5) tick();
    check_outputs("blank_hold");
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
    exp_estate = ESTATE_RES;
    check_outputs("unblank_show");
    tick();
    check_outputs("press_consumed");
    back_to_a(1'b0);

    // idle blanking in ENTER_A, enter press returns to ENTER_A
    sw = 8'h3C;
    repeat (19) tick();
    exp_mem1 = 8'h3C;
    check_outputs("a_last");
    tick();
    exp_estate = ESTATE_OFF;
    check_outputs("blank_a");
    sw = 8'hC3; repeat (3) tick();
    check_outputs("blank_a_hold");
    btn_enter = 1'b1; tick(); btn_enter = 1'b0;
    exp_estate = ESTATE_A;
    check_outputs("unblank_a");
    tick();
    exp_mem1 = 8'hC3;
    check_outputs("a_tracks");

    // held enter gives one transition only
    btn_enter = 1'b1; tick();
    exp_estate = ESTATE_B;
    check_outputs("held_first");
    repeat (9) tick();
    exp_mem2 = sw;
    check_outputs("held_last");
    btn_enter = 1'b0; tick();
    check_outputs("held_release");
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
    exp_estate = ESTATE_A; exp_mem2 = '0;
    check_outputs("held_clear");

    // reset in the middle of CALC
    to_calc(8'h81, 8'h7F, OP_OR);
    tick();
    check_outputs("calc_c2");
    rst = 1'b1; tick(); rst = 1'b0;
    exp_estate = ESTATE_A; exp_mem1 = '0; exp_mem2 = '0; exp_result = '0;
    exp_err = 1'b0; exp_op = 2'd0; exp_start = 1'b0;
    check_outputs("rst_calc");
    alu_done = 1'b1; alu_result = 8'hEE; tick(); alu_done = 1'b0;
    exp_mem1 = sw;
    check_outputs("rst_late_done");

    // random operands, ops and ALU latencies
    for (int i = 0; i < 10; i++) begin
      to_show(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      back_to_a(1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
